// File: rtl/fsic_axil_pkg.sv
// Shared AXI4-Lite definitions for the fsic front-end blocks:
// response codes and the load/store front-end FSM encoding.
package fsic_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    LS_IDLE     = 3'd0,
    LS_WR_ISSUE = 3'd1,
    LS_WR_RESP  = 3'd2,
    LS_RD_ISSUE = 3'd3,
    LS_RD_WAIT  = 3'd4,
    LS_RD_RESP  = 3'd5
  } ls_fe_state_t;

endpackage

// File: rtl/axil_ls_frontend_if.sv
// AXI4-Lite slave channels plus the bk_ls_* backend request/completion port.
interface axil_ls_frontend_if #(
  parameter int ADDR_WIDTH = 15
) ();

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  bk_ls_wstart;
  logic [ADDR_WIDTH-1:0] bk_ls_waddr;
  logic [31:0]           bk_ls_wdata;
  logic [3:0]            bk_ls_wstrb;
  logic                  bk_ls_rstart;
  logic [ADDR_WIDTH-1:0] bk_ls_raddr;
  logic [31:0]           bk_ls_rdata;
  logic                  bk_ls_rdone;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
           bk_ls_rdata, bk_ls_rdone,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           bk_ls_wstart, bk_ls_waddr, bk_ls_wdata, bk_ls_wstrb, bk_ls_rstart, bk_ls_raddr
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
           bk_ls_rdata, bk_ls_rdone,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
           bk_ls_wstart, bk_ls_waddr, bk_ls_wdata, bk_ls_wstrb, bk_ls_rstart, bk_ls_raddr
  );

endinterface

// File: rtl/axil_ls_frontend.sv
// AXI4-Lite slave front end: buffers AW/W/AR one deep each and serializes
// posted writes and timed-out-capable reads onto the single bk_ls_* port.
module axil_ls_frontend
  import fsic_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 15,
  parameter int          RD_TIMEOUT   = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input logic               axi_aclk,
  input logic               axi_aresetn,
  axil_ls_frontend_if.slave bus
);

  localparam int CNT_W = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;

  ls_fe_state_t          state_r, state_s;
  logic                  aw_full_r, w_full_r, ar_full_r, last_rd_r;
  logic [ADDR_WIDTH-1:0] awaddr_r, araddr_r;
  logic [31:0]           wdata_r, rdata_r;
  logic [3:0]            wstrb_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  bvalid_r, rvalid_r, wstart_r, rstart_r;
  logic [1:0]            bresp_r, rresp_r;
  logic                  wr_rdy_s, rd_rdy_s, timeout_s;

  assign wr_rdy_s  = aw_full_r && w_full_r;
  assign rd_rdy_s  = ar_full_r;
  assign timeout_s = (RD_TIMEOUT != 0) && (cnt_r == CNT_W'(RD_TIMEOUT));

  assign bus.awready      = !aw_full_r;
  assign bus.wready       = !w_full_r;
  assign bus.arready      = !ar_full_r;
  assign bus.bvalid       = bvalid_r;
  assign bus.bresp        = bresp_r;
  assign bus.rvalid       = rvalid_r;
  assign bus.rdata        = rdata_r;
  assign bus.rresp        = rresp_r;
  assign bus.bk_ls_wstart = wstart_r;
  assign bus.bk_ls_waddr  = awaddr_r;
  assign bus.bk_ls_wdata  = wdata_r;
  assign bus.bk_ls_wstrb  = wstrb_r;
  assign bus.bk_ls_rstart = rstart_r;
  assign bus.bk_ls_raddr  = araddr_r;

  // One-deep holding registers; a slot frees only when its request issues.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      ar_full_r <= 1'b0;
      awaddr_r  <= {ADDR_WIDTH{1'b0}};
      araddr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
    end else begin
      if (bus.awvalid && !aw_full_r) begin
        aw_full_r <= 1'b1;
        awaddr_r  <= bus.awaddr;
      end else if (state_r == LS_WR_ISSUE) begin
        aw_full_r <= 1'b0;
      end
      if (bus.wvalid && !w_full_r) begin
        w_full_r <= 1'b1;
        wdata_r  <= bus.wdata;
        wstrb_r  <= bus.wstrb;
      end else if (state_r == LS_WR_ISSUE) begin
        w_full_r <= 1'b0;
      end
      if (bus.arvalid && !ar_full_r) begin
        ar_full_r <= 1'b1;
        araddr_r  <= bus.araddr;
      end else if (state_r == LS_RD_ISSUE) begin
        ar_full_r <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r <= LS_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state; on a tie the read wins only if the previous issue was a read,
  // so back-to-back ties alternate and the first tie after reset goes to the write.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LS_IDLE: begin
        if (wr_rdy_s && (!rd_rdy_s || !last_rd_r)) begin
          state_s = LS_WR_ISSUE;
        end else if (rd_rdy_s) begin
          state_s = LS_RD_ISSUE;
        end else begin
          state_s = LS_IDLE;
        end
      end
      LS_WR_ISSUE: state_s = LS_WR_RESP;
      LS_WR_RESP: begin
        if (bvalid_r && bus.bready) begin
          state_s = LS_IDLE;
        end else begin
          state_s = LS_WR_RESP;
        end
      end
      LS_RD_ISSUE: state_s = LS_RD_WAIT;
      LS_RD_WAIT: begin
        if (bus.bk_ls_rdone || timeout_s) begin
          state_s = LS_RD_RESP;
        end else begin
          state_s = LS_RD_WAIT;
        end
      end
      LS_RD_RESP: begin
        if (rvalid_r && bus.rready) begin
          state_s = LS_IDLE;
        end else begin
          state_s = LS_RD_RESP;
        end
      end
      default: state_s = LS_IDLE;
    endcase
  end

  // Backend pulses, arbitration history, read timer and response channels.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wstart_r  <= 1'b0;
      rstart_r  <= 1'b0;
      last_rd_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= AXI_RESP_OKAY;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= AXI_RESP_OKAY;
    end else begin
      wstart_r <= (state_s == LS_WR_ISSUE);
      rstart_r <= (state_s == LS_RD_ISSUE);
      if (state_r == LS_WR_ISSUE) begin
        last_rd_r <= 1'b0;
      end else if (state_r == LS_RD_ISSUE) begin
        last_rd_r <= 1'b1;
      end
      // The timer saturates so a disabled or very long wait never wraps.
      if (state_r == LS_RD_ISSUE) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == LS_RD_WAIT) && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
      if (state_r == LS_WR_ISSUE) begin
        bvalid_r <= 1'b1;
        bresp_r  <= AXI_RESP_OKAY;
      end else if (bvalid_r && bus.bready) begin
        bvalid_r <= 1'b0;
      end
      if ((state_r == LS_RD_WAIT) && bus.bk_ls_rdone) begin
        rvalid_r <= 1'b1;
        rdata_r  <= bus.bk_ls_rdata;
        rresp_r  <= AXI_RESP_OKAY;
      end else if ((state_r == LS_RD_WAIT) && timeout_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= TIMEOUT_DATA;
        rresp_r  <= AXI_RESP_SLVERR;
      end else if (rvalid_r && bus.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_ls_frontend.sv
// Bench for axil_ls_frontend: directed vector table, multi-cycle corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_axil_ls_frontend;
  import fsic_axil_pkg::*;

  localparam int AW  = 15;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_ls_frontend_if #(.ADDR_WIDTH(AW)) bus ();

  axil_ls_frontend #(
    .ADDR_WIDTH  (AW),
    .RD_TIMEOUT  (TMO),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .axi_aclk   (clk),
    .axi_aresetn(rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_delay = -1;
  logic [31:0] rd_val = 32'h0;
  int stray_req = 0;

  typedef struct {
    bit          rd;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          c;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    int            w_lead;
    int            rd_dly;
    int            stall;
    logic [31:0]   exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;
  vec_t vecs[7];

  function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [127:0] outs();
    return {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.bresp, bus.rvalid,
            bus.rresp, bus.rdata, bus.bk_ls_wstart, bus.bk_ls_waddr, bus.bk_ls_wdata,
            bus.bk_ls_wstrb, bus.bk_ls_rstart, bus.bk_ls_raddr};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Backend monitor: logs every request pulse and flags simultaneous pulses.
  always @(negedge clk) begin
    if (bus.bk_ls_wstart || bus.bk_ls_rstart) begin
      check("one_pulse_per_cycle", {bus.bk_ls_wstart, bus.bk_ls_rstart} == 2'b11, 1'b0);
      evq.push_back('{rd: bus.bk_ls_rstart,
                      addr: bus.bk_ls_rstart ? bus.bk_ls_raddr : bus.bk_ls_waddr,
                      data: bus.bk_ls_wdata, strb: bus.bk_ls_wstrb, c: cyc});
    end
  end

  // Backend read responder plus on-demand stray completions.
  initial begin
    int stray_done;
    stray_done = 0;
    bus.bk_ls_rdone = 1'b0;
    bus.bk_ls_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.bk_ls_rstart && rd_delay >= 0) begin
        repeat (rd_delay) @(posedge clk);
        #1;
        bus.bk_ls_rdata = rd_val;
        bus.bk_ls_rdone = 1'b1;
        @(posedge clk); #1;
        bus.bk_ls_rdone = 1'b0;
        bus.bk_ls_rdata = 32'h0;
      end else if (stray_req != stray_done) begin
        stray_done++;
        @(posedge clk); #1;
        bus.bk_ls_rdata = 32'hBAD0_BAD0;
        bus.bk_ls_rdone = 1'b1;
        @(posedge clk); #1;
        bus.bk_ls_rdone = 1'b0;
        bus.bk_ls_rdata = 32'h0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [AW-1:0] a, output int hc);
    hc = -1;
    bus.awaddr = a; bus.awvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.awready) begin hc = cyc; break; end
    end
    check("aw_handshake", hc >= 0, 1'b1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hc);
    hc = -1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.wready) begin hc = cyc; break; end
    end
    check("w_handshake", hc >= 0, 1'b1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, output int hc);
    hc = -1;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.arready) begin hc = cyc; break; end
    end
    check("ar_handshake", hc >= 0, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic get_b(input int stall, output logic [1:0] resp, output int vc);
    vc = -1; resp = 2'b11;
    bus.bready = (stall == 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.bvalid) begin vc = cyc; resp = bus.bresp; break; end
    end
    check("b_seen", vc >= 0, 1'b1);
    if (vc >= 0) begin
      repeat (stall) begin
        @(negedge clk);
        check("b_hold", {bus.bvalid, bus.bresp}, {1'b1, resp});
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
    end
    bus.bready = 1'b0;
  endtask

  task automatic get_r(input int stall, output logic [31:0] d, output logic [1:0] r, output int vc);
    vc = -1; d = 32'h0; r = 2'b11;
    bus.rready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rvalid) begin vc = cyc; d = bus.rdata; r = bus.rresp; break; end
    end
    check("r_seen", vc >= 0, 1'b1);
    if (vc >= 0) begin
      repeat (stall) begin
        @(negedge clk);
        check("r_hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, d, r});
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int w_lead, input int bstall,
                          output int later, output int vc, output logic [1:0] resp);
    int ha, hw;
    fork
      begin if (w_lead < 0) tick(-w_lead); send_aw(a, ha); end
      begin if (w_lead > 0) tick(w_lead); send_w(d, s, hw); end
    join
    later = (ha > hw) ? ha : hw;
    get_b(bstall, resp, vc);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input logic [31:0] val,
                         input int stall, output int hc, output logic [31:0] d,
                         output logic [1:0] r, output int vc);
    rd_delay = dly; rd_val = val;
    send_ar(a, hc);
    get_r(stall, d, r, vc);
  endtask

  // Both channels become ready in the same cycle; exp_order = {first.rd, second.rd}.
  task automatic do_pair(input logic [1:0] exp_order, input logic [AW-1:0] a);
    evq.delete();
    rd_delay = 2; rd_val = {17'h0, a};
    fork
      begin int h; send_aw(a, h); end
      begin int h; send_w(32'h5555_0000 | 32'(a), 4'hF, h); end
      begin int h; send_ar(a + 15'h0004, h); end
    join
    fork
      begin int v; logic [1:0] rr; get_b(0, rr, v); check("arb_bresp", rr, AXI_RESP_OKAY); end
      begin int v; logic [31:0] dd; logic [1:0] rr; get_r(0, dd, rr, v); check("arb_rdata", dd, {17'h0, a}); end
    join
    check("arb_count", evq.size(), 2);
    if (evq.size() == 2) check("arb_order", {evq[0].rd, evq[1].rd}, exp_order);
  endtask

  initial begin
    logic [127:0] rst_exp;
    int hc, vc, later, saw;
    logic [31:0] d;
    logic [1:0] r;

    vecs[0] = '{1'b0, 15'h0010, 32'h1234_5678, 4'hF,  0,  0, 0, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 15'h0020, 32'hA5A5_0F0F, 4'h3,  3,  0, 0, 32'h0,         2'b00};
    vecs[2] = '{1'b1, 15'h0100, 32'hCAFE_F00D, 4'h0,  0,  5, 0, 32'hCAFE_F00D, 2'b00};
    vecs[3] = '{1'b1, 15'h0100, 32'hCAFE_F00D, 4'h0,  0,  5, 4, 32'hCAFE_F00D, 2'b00};
    vecs[4] = '{1'b1, 15'h0200, 32'h1111_2222, 4'h0,  0, -1, 2, 32'hDEAD_BEEF, 2'b10};
    vecs[5] = '{1'b0, 15'h7FFC, 32'hFFFF_FFFF, 4'h0, -2,  0, 2, 32'h0,         2'b00};
    vecs[6] = '{1'b1, 15'h7FFF, 32'h0000_0001, 4'h0,  0,  1, 1, 32'h0000_0001, 2'b00};

    bus.awvalid = 1'b0; bus.awaddr = 15'h0;
    bus.wvalid = 1'b0; bus.wdata = 32'h0; bus.wstrb = 4'h0;
    bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = 15'h0; bus.rready = 1'b0;
    rst_exp = 128'd0;
    rst_exp[108:106] = 3'b111;

    tick(3);
    @(negedge clk);
    check("reset_outputs", outs(), rst_exp);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      evq.delete();
      if (!vecs[i].is_rd) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].w_lead, vecs[i].stall, later, vc, r);
        check("wr_bresp", r, vecs[i].exp_resp);
        check("wr_bvalid_latency", vc, later + 3);
        check("wr_pulse_count", evq.size(), 1);
        if (evq.size() == 1) begin
          check("wr_payload", {evq[0].rd, evq[0].addr, evq[0].data, evq[0].strb},
                {1'b0, vecs[i].addr, vecs[i].data, vecs[i].strb});
          check("wr_wstart_latency", evq[0].c, later + 2);
        end
      end else begin
        do_read(vecs[i].addr, vecs[i].rd_dly, vecs[i].data, vecs[i].stall, hc, d, r, vc);
        check("rd_rdata", d, vecs[i].exp_rdata);
        check("rd_rresp", r, vecs[i].exp_resp);
        check("rd_pulse_count", evq.size(), 1);
        if (evq.size() == 1) begin
          check("rd_req", {evq[0].rd, evq[0].addr}, {1'b1, vecs[i].addr});
          check("rd_rstart_latency", evq[0].c, hc + 2);
        end
        if (vecs[i].rd_dly >= 0) check("rd_rvalid_latency", vc, hc + 3 + vecs[i].rd_dly);
      end
      tick(2);
    end

    // Timeout, then a stray completion must not produce a response.
    do_read(15'h0400, -1, 32'h0, 0, hc, d, r, vc);
    check("tmo_resp", {d, r}, {32'hDEAD_BEEF, AXI_RESP_SLVERR});
    stray_req++;
    saw = 0;
    repeat (5) begin @(negedge clk); if (bus.rvalid) saw = 1; end
    check("stray_rdone_ignored", saw, 0);
    tick(1);
    do_read(15'h0404, 3, 32'h1357_9BDF, 0, hc, d, r, vc);
    check("after_tmo_read", {d, r}, {32'h1357_9BDF, AXI_RESP_OKAY});
    tick(2);

    // Arbitration: a write primes history, then two ties alternate.
    do_write(15'h0030, 32'h0BAD_F00D, 4'hF, 0, 0, later, vc, r);
    tick(2);
    do_pair(2'b01, 15'h0040);
    tick(2);
    do_pair(2'b10, 15'h0080);
    tick(2);

    // Randomized traffic against a transaction-level model.
    for (int it = 0; it < 40; it++) begin
      bit do_wr, do_rd;
      logic [AW-1:0] wa, ra;
      logic [31:0] wd, rv, exp_d;
      logic [3:0] ws;
      logic [1:0] exp_r;
      int lead, gap, dly, bst, rst_c;
      do_wr = 1'($urandom()); do_rd = 1'($urandom());
      if (!do_wr && !do_rd) do_wr = 1'b1;
      wa = AW'($urandom()); ra = AW'($urandom());
      wd = $urandom(); rv = $urandom(); ws = 4'($urandom());
      lead = int'($urandom_range(0, 6)) - 3;
      gap = int'($urandom_range(0, 4));
      dly = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 6));
      bst = int'($urandom_range(0, 3)); rst_c = int'($urandom_range(0, 3));
      exp_d = (dly < 0) ? 32'hDEAD_BEEF : rv;
      exp_r = (dly < 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      evq.delete();
      fork
        begin
          if (do_wr) begin
            int l, v; logic [1:0] br;
            do_write(wa, wd, ws, lead, bst, l, v, br);
            check("rnd_bresp", br, AXI_RESP_OKAY);
          end
        end
        begin
          if (do_rd) begin
            int h, v; logic [31:0] rd; logic [1:0] rr;
            if (gap > 0) tick(gap);
            do_read(ra, dly, rv, rst_c, h, rd, rr, v);
            check("rnd_rdata", {rd, rr}, {exp_d, exp_r});
          end
        end
      join
      check("rnd_pulse_count", evq.size(), int'(do_wr) + int'(do_rd));
      foreach (evq[k]) begin
        if (!evq[k].rd) check("rnd_wr_payload", {evq[k].addr, evq[k].data, evq[k].strb}, {wa, wd, ws});
        else            check("rnd_rd_addr", evq[k].addr, ra);
      end
      tick(1);
    end

    // Reset while waiting for a read completion.
    evq.delete();
    rd_delay = -1;
    send_ar(15'h0300, hc);
    tick(3);
    check("rst_rstart_seen", evq.size(), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", outs(), rst_exp);
    tick(2);
    evq.delete();
    rst_n = 1'b1;
    saw = 0;
    repeat (30) begin @(negedge clk); if (bus.rvalid) saw = 1; end
    check("rst_no_rvalid", saw, 0);
    check("rst_no_pulse", evq.size(), 0);
    tick(1);
    do_read(15'h0308, 2, 32'h2468_ACE0, 0, hc, d, r, vc);
    check("rst_recover_read", {d, r}, {32'h2468_ACE0, AXI_RESP_OKAY});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
